// File: rtl/fpalu_pipe_if.sv
// rtl/fpalu_pipe_if.sv - operand/result stream bundle for fpalu_pipe
//
// Parameters: AEW exponent width, AMW mantissa width, TAGW sideband tag width.
// Operand side: in_valid/in_ready handshake, in_op, a/b sign, exponent and
// mantissa, in_tag.
// Result side: out_valid/out_ready handshake, out_sgn/out_exp/out_man,
// out_ovf, out_tag.
// master: transaction source and result consumer. slave: the pipeline.

interface fpalu_pipe_if #(
    parameter int AEW  = 6,
    parameter int AMW  = 22,
    parameter int TAGW = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic            in_a_sgn;
    logic            in_b_sgn;
    logic [AEW-1:0]  in_a_exp;
    logic [AEW-1:0]  in_b_exp;
    logic [AMW-1:0]  in_a_man;
    logic [AMW-1:0]  in_b_man;
    logic [TAGW-1:0] in_tag;

    logic            out_valid;
    logic            out_ready;
    logic            out_sgn;
    logic [AEW-1:0]  out_exp;
    logic [AMW-1:0]  out_man;
    logic            out_ovf;
    logic [TAGW-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a_sgn, in_b_sgn, in_a_exp, in_b_exp,
               in_a_man, in_b_man, in_tag, out_ready,
        input  in_ready, out_valid, out_sgn, out_exp, out_man, out_ovf, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a_sgn, in_b_sgn, in_a_exp, in_b_exp,
               in_a_man, in_b_man, in_tag, out_ready,
        output in_ready, out_valid, out_sgn, out_exp, out_man, out_ovf, out_tag
    );
endinterface

// File: rtl/fpalu_pipe.sv
// rtl/fpalu_pipe.sv - 4-stage flow-controlled FP add/sub/mul/pass unit
//
// Ports: clk, rst_n (async active-low), bus (fpalu_pipe_if.slave) carrying
// the operand stream (in_*) and the result stream (out_*).
// Stages: S1 unpack/zero detect/exponent compare, S2 align + multiply,
// S3 add/sub, S4 leading-zero count and normalise into the output registers.
// Optional: FPALU_PIPE_SATURATE_EN saturates overflowed results to all ones
// instead of wrapping the exponent.

module fpalu_pipe #(
    parameter int AEW  = 6,
    parameter int AMW  = 22,
    parameter int TAGW = 4
) (
    input logic          clk,
    input logic          rst_n,
    fpalu_pipe_if.slave  bus
);
    localparam int EW  = AEW + 2;
    localparam int HW  = AMW / 2;
    localparam int LZW = $clog2(AMW + 1);
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (AEW - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << AEW) - 1);

    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_PASS = 2'b11} op_t;

    // One enable moves every stage; bubbles travel with the data.
    logic en;
    assign en = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;

    // ---------------- S1 ----------------
    logic                  a_zero_c, b_zero_c, a_big_c;
    logic [AEW-1:0]        diff_c;
    logic signed [EW-1:0]  mexp_c;

    logic                  s1_v, s1_as, s1_bs, s1_a_big;
    op_t                   s1_op;
    logic [TAGW-1:0]       s1_tag;
    logic [AEW-1:0]        s1_ae, s1_be, s1_diff;
    logic [AMW-1:0]        s1_am, s1_bm;
    logic signed [EW-1:0]  s1_mexp;

    always_comb begin
        a_zero_c = (bus.in_a_man == '0);
        b_zero_c = (bus.in_b_man == '0);
        // A zero operand never wins the exponent compare; the other one is
        // taken as the large operand and the zero contributes a 0 mantissa.
        a_big_c  = b_zero_c || (!a_zero_c && (bus.in_a_exp >= bus.in_b_exp));
        if (a_zero_c || b_zero_c)
            diff_c = '0;
        else if (a_big_c)
            diff_c = bus.in_a_exp - bus.in_b_exp;
        else
            diff_c = bus.in_b_exp - bus.in_a_exp;
        mexp_c = $signed({2'b00, bus.in_a_exp}) + $signed({2'b00, bus.in_b_exp}) - BIAS;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0; s1_op <= OP_ADD; s1_tag <= '0;
            s1_as <= 1'b0; s1_bs <= 1'b0; s1_a_big <= 1'b0;
            s1_ae <= '0; s1_be <= '0; s1_diff <= '0;
            s1_am <= '0; s1_bm <= '0; s1_mexp <= '0;
        end else if (en) begin
            s1_v     <= bus.in_valid;
            s1_op    <= op_t'(bus.in_op);
            s1_tag   <= bus.in_tag;
            s1_as    <= bus.in_a_sgn;
            s1_bs    <= bus.in_b_sgn ^ (op_t'(bus.in_op) == OP_SUB);
            s1_a_big <= a_big_c;
            s1_ae    <= bus.in_a_exp;
            s1_be    <= bus.in_b_exp;
            s1_diff  <= diff_c;
            s1_am    <= bus.in_a_man;
            s1_bm    <= bus.in_b_man;
            s1_mexp  <= mexp_c;
        end
    end

    // ---------------- S2 ----------------
    logic [AMW-1:0]        prod_c, big_c, small_c;
    logic                  bsg_c, ssg_c;
    logic signed [EW-1:0]  exp2_c;

    logic                  s2_v, s2_bsg, s2_ssg;
    logic [TAGW-1:0]       s2_tag;
    logic [AMW-1:0]        s2_big, s2_small;
    logic signed [EW-1:0]  s2_exp;

    // Upper mantissa halves multiply exactly into AMW bits.
    assign prod_c = {{HW{1'b0}}, s1_am[AMW-1 -: HW]} * {{HW{1'b0}}, s1_bm[AMW-1 -: HW]};

    always_comb begin
        big_c   = s1_am;
        small_c = '0;
        bsg_c   = s1_as;
        ssg_c   = s1_as;
        exp2_c  = {2'b00, s1_ae};
        case (s1_op)
            OP_MUL: begin
                big_c  = prod_c;
                bsg_c  = s1_as ^ s1_bs;
                ssg_c  = s1_as ^ s1_bs;
                exp2_c = s1_mexp;
            end
            OP_PASS: ;
            default: begin
                if (s1_a_big) begin
                    small_c = s1_bm >> s1_diff;
                    ssg_c   = s1_bs;
                end else begin
                    big_c   = s1_bm;
                    bsg_c   = s1_bs;
                    small_c = s1_am >> s1_diff;
                    exp2_c  = {2'b00, s1_be};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v <= 1'b0; s2_tag <= '0; s2_bsg <= 1'b0; s2_ssg <= 1'b0;
            s2_big <= '0; s2_small <= '0; s2_exp <= '0;
        end else if (en) begin
            s2_v     <= s1_v;
            s2_tag   <= s1_tag;
            s2_bsg   <= bsg_c;
            s2_ssg   <= ssg_c;
            s2_big   <= big_c;
            s2_small <= small_c;
            s2_exp   <= exp2_c;
        end
    end

    // ---------------- S3 ----------------
    logic [AMW:0]          sum_c;
    logic                  sg3_c;

    logic                  s3_v, s3_sg;
    logic [TAGW-1:0]       s3_tag;
    logic [AMW:0]          s3_sum;
    logic signed [EW-1:0]  s3_exp;

    // With equal exponents the exponent-larger operand may still be the
    // smaller magnitude, so the subtract direction is chosen on mantissas.
    always_comb begin
        sg3_c = s2_bsg;
        if (s2_bsg == s2_ssg) begin
            sum_c = {1'b0, s2_big} + {1'b0, s2_small};
        end else if (s2_big >= s2_small) begin
            sum_c = {1'b0, s2_big - s2_small};
        end else begin
            sum_c = {1'b0, s2_small - s2_big};
            sg3_c = s2_ssg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_v <= 1'b0; s3_tag <= '0; s3_sg <= 1'b0; s3_sum <= '0; s3_exp <= '0;
        end else if (en) begin
            s3_v   <= s2_v;
            s3_tag <= s2_tag;
            s3_sg  <= sg3_c;
            s3_sum <= sum_c;
            s3_exp <= s2_exp;
        end
    end

    // ---------------- S4 ----------------
    logic [LZW-1:0]        lzc;
    logic signed [EW-1:0]  lz_e, sh, n_exp;
    logic [EW-1:0]         rsh;
    logic [AMW-1:0]        n_man, o_man;
    logic [AEW-1:0]        o_exp;
    logic                  n_zero, o_ovf, o_sgn;

    always_comb begin
        lzc = LZW'(AMW);
        for (int i = 0; i < AMW; i++)
            if (s3_sum[i]) lzc = LZW'(AMW - 1 - i);
        lz_e  = {{(EW-LZW){1'b0}}, lzc};
        sh    = '0;
        rsh   = '0;
        n_exp = s3_exp;
        if (s3_sum[AMW]) begin
            n_man = s3_sum[AMW:1];
            n_exp = s3_exp + EW'(1);
        end else if (s3_exp[EW-1]) begin
            // Negative working exponent (MUL underflow): denormalise, truncate.
            rsh   = -s3_exp;
            n_man = s3_sum[AMW-1:0] >> rsh;
            n_exp = '0;
        end else begin
            // Left shift stops at exponent 0, producing a denormal.
            sh    = (lz_e < s3_exp) ? lz_e : s3_exp;
            n_man = s3_sum[AMW-1:0] << sh;
            n_exp = s3_exp - sh;
        end
        n_zero = (n_man == '0);
        o_ovf  = !n_zero && (n_exp > EMAX);
        o_sgn  = n_zero ? 1'b0 : s3_sg;
        o_exp  = n_zero ? '0 : n_exp[AEW-1:0];
        o_man  = n_man;
`ifdef FPALU_PIPE_SATURATE_EN
        if (o_ovf) begin
            o_exp = '1;
            o_man = '1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_sgn   <= 1'b0;
            bus.out_exp   <= '0;
            bus.out_man   <= '0;
            bus.out_ovf   <= 1'b0;
            bus.out_tag   <= '0;
        end else if (en) begin
            bus.out_valid <= s3_v;
            bus.out_sgn   <= o_sgn;
            bus.out_exp   <= o_exp;
            bus.out_man   <= o_man;
            bus.out_ovf   <= o_ovf;
            bus.out_tag   <= s3_tag;
        end
    end
endmodule
